// File: rtl/bitonic_frame_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : bitonic_frame_loader_if
//  Brief    : Key-stream input and packed-frame output handshake bundle for
//             the bitonic frame loader.
//  Revision : 1.0  initial release
// ============================================================================
interface bitonic_frame_loader_if #(
    parameter int NUM = 16,
    parameter int W   = 16,
    parameter int CW  = $clog2(NUM + 1)
) ();
    // Serial key stream
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic             in_dir;

    // Packed frame toward the sorting network
    logic [NUM*W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_dir;
    logic [CW-1:0]    out_count;

    // Loader side
    modport slave (
        input  in_data, in_valid, in_last, in_dir, out_ready,
        output in_ready, out_data, out_valid, out_dir, out_count
    );

    // Stream source / frame sink side
    modport master (
        output in_data, in_valid, in_last, in_dir, out_ready,
        input  in_ready, out_data, out_valid, out_dir, out_count
    );
endinterface
`default_nettype wire

// File: rtl/bitonic_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : bitonic_frame_loader
//  Brief    : Packs a valid/ready stream of W-bit keys into NUM-key frames,
//             pads short frames with the sort-neutral value for the latched
//             direction, and presents each frame under valid/ready. A fill
//             buffer plus an output register lets the next frame load while
//             the current one waits downstream.
//  Revision : 1.0  initial release
// ============================================================================
module bitonic_frame_loader #(
    parameter int NUM = 16,
    parameter int W   = 16,
    parameter int CW  = $clog2(NUM + 1)
) (
    input  wire logic              clk,
    input  wire logic              rst,    // asynchronous, active low
    bitonic_frame_loader_if.slave  bus
);

    localparam int             PW          = $clog2(NUM);
    localparam logic [PW-1:0]  c_last_slot = PW'(NUM - 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [PW-1:0]      r_wr_ptr;
    logic [W-1:0]       r_fill [NUM];
    logic               r_fill_dir;
    logic [CW-1:0]      r_fill_count;

    logic [NUM*W-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_out_dir;
    logic [CW-1:0]      r_out_count;

    logic               w_fill_full;
    logic               w_accept;
    logic               w_close;
    logic               w_xfer;
    logic               w_dir_eff;
    logic [W-1:0]       w_pad;
    logic [NUM*W-1:0]   w_fill_flat;

    // Handshake qualifiers. in_ready comes only from the state register, so
    // there is no combinational path from out_ready back to in_ready.
    assign w_fill_full = (r_state == S_FULL);
    assign w_accept    = bus.in_valid && !w_fill_full;
    assign w_close     = w_accept && ((r_wr_ptr == c_last_slot) || bus.in_last);
    assign w_xfer      = w_fill_full && (!r_out_valid || bus.out_ready);

    // On the first word the direction is not yet latched, so the live in_dir
    // decides the pad value for a single-word frame.
    assign w_dir_eff   = (r_wr_ptr == '0) ? bus.in_dir : r_fill_dir;
    assign w_pad       = {W{w_dir_eff}};

    // Flatten the fill buffer so key k sits at bits [W*k+W-1 : W*k]
    for (genvar k = 0; k < NUM; k++) begin : g_pack
        assign w_fill_flat[W*k +: W] = r_fill[k];
    end

    // Fill-side state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_FILL;
        else      r_state <= w_state_nxt;
    end

    // Fill-side next state: close a frame to FULL, hand it off back to FILL
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (w_close) w_state_nxt = S_FULL;
            S_FULL:  if (w_xfer)  w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Write pointer, direction latch and key count of the frame being filled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_fill_dir   <= 1'b0;
            r_fill_count <= '0;
        end else if (w_accept) begin
            if (r_wr_ptr == '0) r_fill_dir <= bus.in_dir;
            if (w_close) begin
                r_wr_ptr     <= '0;
                r_fill_count <= CW'(r_wr_ptr) + CW'(1);
            end else begin
                r_wr_ptr     <= r_wr_ptr + PW'(1);
            end
        end
    end

    // Fill buffer: store the key at wr_ptr; on close pad every later slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM; k++) r_fill[k] <= '0;
        end else begin
            for (int k = 0; k < NUM; k++) begin
                if (w_accept && (r_wr_ptr == PW'(k)))
                    r_fill[k] <= bus.in_data;
                else if (w_close && (PW'(k) > r_wr_ptr))
                    r_fill[k] <= w_pad;
            end
        end
    end

    // Output register: load a full frame when free or being consumed,
    // otherwise drop valid once the consumer takes the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_dir   <= 1'b0;
            r_out_count <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_fill_flat;
            r_out_valid <= 1'b1;
            r_out_dir   <= r_fill_dir;
            r_out_count <= r_fill_count;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = !w_fill_full;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_dir   = r_out_dir;
    assign bus.out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_bitonic_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitonic_frame_loader
//  Brief    : Directed, table-driven bench for bitonic_frame_loader with
//             NUM = 4, W = 8, plus backpressure and mid-frame reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bitonic_frame_loader;

    localparam int NUM = 4;
    localparam int W   = 8;
    localparam int CW  = $clog2(NUM + 1);

    typedef struct {
        int               n;
        logic             dir;
        logic             use_last;
        logic [3:0][7:0]  keys;
        logic [31:0]      exp_data;
        logic [2:0]       exp_cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   passed;
    logic [31:0] got[$];
    vec_t tbl[5];

    bitonic_frame_loader_if #(.NUM(NUM), .W(W), .CW(CW)) bus ();

    bitonic_frame_loader #(.NUM(NUM), .W(W), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every frame handshake for the ordering check
    always @(posedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded wait)
    task automatic send(input logic [7:0] d, input logic l, input logic dir);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_dir   = dir;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!bus.in_ready) chk("in_ready_wait", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'hEE;
        bus.in_dir   = ~dir;
    endtask

    // After the closing accept: one bubble, one valid cycle, then idle
    task automatic expect_frame(input string tag, input logic [31:0] data,
                                input logic dir, input logic [2:0] cnt);
        chk({tag, "_lat_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, "_lat_ready"}, {31'b0, bus.in_ready},  32'd0);
        tick();
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, "_data"},  bus.out_data,           data);
        chk({tag, "_dir"},   {31'b0, bus.out_dir},   {31'b0, dir});
        chk({tag, "_count"}, {29'b0, bus.out_count}, {29'b0, cnt});
        tick();
        chk({tag, "_onecyc"}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int start;
        checks = 0;
        passed = 0;

        tbl[0] = '{4, 1'b1, 1'b0, {8'h44, 8'h33, 8'h22, 8'h11}, 32'h44332211, 3'd4};
        tbl[1] = '{2, 1'b0, 1'b1, {8'h00, 8'h00, 8'h06, 8'h05}, 32'h00000605, 3'd2};
        tbl[2] = '{2, 1'b1, 1'b1, {8'h00, 8'h00, 8'h06, 8'h05}, 32'hFFFF0605, 3'd2};
        tbl[3] = '{1, 1'b1, 1'b1, {8'h00, 8'h00, 8'h00, 8'h7A}, 32'hFFFFFF7A, 3'd1};
        tbl[4] = '{4, 1'b0, 1'b1, {8'h04, 8'h03, 8'h02, 8'h01}, 32'h04030201, 3'd4};

        rst           = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_dir    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  bus.out_data,           32'd0);
        chk("rst_out_count", {29'b0, bus.out_count}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Table-driven frames, out_ready held high; non-first words carry
        // the opposite direction, which must be ignored
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                send(tbl[i].keys[j], tbl[i].use_last && (j == tbl[i].n - 1),
                     (j == 0) ? tbl[i].dir : ~tbl[i].dir);
            end
            expect_frame($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].dir, tbl[i].exp_cnt);
        end

        // Backpressure: three frames streamed while the output is stalled
        bus.out_ready = 1'b0;
        start = got.size();
        for (int j = 0; j < 4; j++) send(8'(8'hA1 + j), 1'b0, j == 0);
        for (int j = 0; j < 4; j++) send(8'(8'hB1 + j), 1'b0, 1'b0);
        chk("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("bp_hold_data",  bus.out_data,           32'hA4A3A2A1);
        chk("bp_hold_dir",   {31'b0, bus.out_dir},   32'd1);
        bus.in_data  = 8'hC1;
        bus.in_dir   = 1'b1;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        tick();
        tick();
        chk("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
        chk("bp_still_A",      bus.out_data,          32'hA4A3A2A1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_swap_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("bp_swap_data",  bus.out_data,           32'hB4B3B2B1);
        chk("bp_swap_dir",   {31'b0, bus.out_dir},   32'd0);
        chk("bp_swap_ready", {31'b0, bus.in_ready},  32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_B_consumed", {31'b0, bus.out_valid}, 32'd0);
        for (int j = 1; j < 4; j++) send(8'(8'hC1 + j), 1'b0, 1'b0);
        expect_frame("bp_C", 32'hC4C3C2C1, 1'b1, 3'd4);
        chk("bp_frames", got.size() - start, 32'd3);
        if (got.size() - start == 3) begin
            chk("bp_order0", got[start],     32'hA4A3A2A1);
            chk("bp_order1", got[start + 1], 32'hB4B3B2B1);
            chk("bp_order2", got[start + 2], 32'hC4C3C2C1);
        end

        // Reset in the middle of a frame
        send(8'hD1, 1'b0, 1'b0);
        send(8'hD2, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mid_rst_data",  bus.out_data,           32'd0);
        chk("mid_rst_dir",   {31'b0, bus.out_dir},   32'd0);
        chk("mid_rst_count", {29'b0, bus.out_count}, 32'd0);
        chk("mid_rst_ready", {31'b0, bus.in_ready},  32'd1);
        #1;
        rst = 1'b1;
        tick();
        for (int j = 0; j < 4; j++) send(8'(8'hE1 + j), 1'b0, j == 0);
        expect_frame("post_rst", 32'hE4E3E2E1, 1'b1, 3'd4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
